// File: rtl/traffic_pkg.sv
// ============================================================================
// Module : traffic_pkg
// Brief  : Shared pedestrian-crossing state encodings and lamp constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [1:0] {
        ST_DONT_WALK = 2'd0,
        ST_WALK      = 2'd1,
        ST_CLEAR     = 2'd2,
        ST_FAULT     = 2'd3
    } ped_state_t;

    localparam logic c_LAMP_ON  = 1'b1;
    localparam logic c_LAMP_OFF = 1'b0;

    // True when two or more vehicle lamps are lit together.
    function automatic logic lamps_conflict(input logic red, input logic green, input logic yellow);
        return (red & green) | (red & yellow) | (green & yellow);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : 2-FF synchroniser, tick-based debounce and rising-edge press pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int CNT_W          = 4,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn_raw,
    output logic o_press_ev
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_differs;
    logic w_accept;

    assign w_differs  = r_sync2 != r_level;
    assign w_accept   = i_tick & w_differs & (r_cnt == c_LAST);
    assign o_press_ev = r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            r_press <= w_accept & r_sync2;
            // A tick that agrees with the accepted level restarts the run.
            if (i_tick) begin
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ped_crossing_ctrl.sv
// ============================================================================
// Module : ped_crossing_ctrl
// Brief  : Pedestrian crossing controller slaved to the vehicle light FSM.
//          Optional countdown output enabled by defining PED_COUNTDOWN_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ped_crossing_ctrl #(
    parameter int CNT_W          = 4,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int WALK_TICKS     = 6,
    parameter int CLEAR_TICKS    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_raw,
    input  logic             veh_red,
    input  logic             veh_green,
    input  logic             veh_yellow,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic             fault
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0] countdown
`endif
);

    import traffic_pkg::*;

    localparam logic [CNT_W-1:0] c_WALK_LAST  = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] c_CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    ped_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_red_q;
    logic             r_walk;
    logic             r_dont_walk;
    logic             r_req;
    logic             r_fault;

    logic w_press_ev;
    logic w_red_rise;
    logic w_unsafe;
    logic w_to_fault;
    logic w_go_walk;

    btn_debounce #(
        .CNT_W          (CNT_W),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_btn_debounce (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (tick),
        .i_btn_raw  (btn_raw),
        .o_press_ev (w_press_ev)
    );

    assign w_red_rise = veh_red & ~r_red_q;
    // Red must stay lit for the whole time pedestrians own the crossing.
    assign w_unsafe   = lamps_conflict(veh_red, veh_green, veh_yellow)
                      | (~veh_red & ((r_state == ST_WALK) || (r_state == ST_CLEAR)));
    assign w_to_fault = w_unsafe | (r_state == ST_FAULT);
    assign w_go_walk  = (r_state == ST_DONT_WALK) & w_red_rise & (r_req | w_press_ev);

    assign walk        = r_walk;
    assign dont_walk   = r_dont_walk;
    assign req_pending = r_req;
    assign fault       = r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red_q <= 1'b0;
        end else begin
            r_red_q <= veh_red;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_DONT_WALK;
            r_cnt       <= '0;
            r_walk      <= c_LAMP_OFF;
            r_dont_walk <= c_LAMP_ON;
            r_req       <= 1'b0;
            r_fault     <= 1'b0;
        end else if (w_to_fault) begin
            r_state     <= ST_FAULT;
            r_cnt       <= '0;
            r_walk      <= c_LAMP_OFF;
            r_dont_walk <= c_LAMP_ON;
            r_fault     <= 1'b1;
        end else begin
            case (r_state)
                ST_DONT_WALK: begin
                    if (w_go_walk) begin
                        r_state     <= ST_WALK;
                        r_cnt       <= '0;
                        r_walk      <= c_LAMP_ON;
                        r_dont_walk <= c_LAMP_OFF;
                        r_req       <= 1'b0;
                    end else if (w_press_ev) begin
                        r_req <= 1'b1;
                    end
                end
                ST_WALK: begin
                    if (tick) begin
                        if (r_cnt == c_WALK_LAST) begin
                            r_state     <= ST_CLEAR;
                            r_cnt       <= '0;
                            r_walk      <= c_LAMP_OFF;
                            r_dont_walk <= c_LAMP_ON;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (w_press_ev) begin
                        r_req <= 1'b1;
                    end
                    if (tick) begin
                        if (r_cnt == c_CLEAR_LAST) begin
                            r_state     <= ST_DONT_WALK;
                            r_cnt       <= '0;
                            r_dont_walk <= c_LAMP_ON;
                        end else begin
                            r_cnt       <= r_cnt + c_ONE;
                            r_dont_walk <= ~r_dont_walk;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_FAULT;
                    r_walk      <= c_LAMP_OFF;
                    r_dont_walk <= c_LAMP_ON;
                    r_fault     <= 1'b1;
                end
            endcase
        end
    end

`ifdef PED_COUNTDOWN_EN
    localparam logic [CNT_W-1:0] c_TOTAL = CNT_W'(WALK_TICKS + CLEAR_TICKS);

    logic [CNT_W-1:0] r_countdown;

    assign countdown = r_countdown;

    // Loaded with the full crossing time on WALK entry, then one step per tick
    // through WALK and CLEAR, reaching 0 exactly as CLEAR ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_countdown <= '0;
        end else if (w_to_fault) begin
            r_countdown <= '0;
        end else if (w_go_walk) begin
            r_countdown <= c_TOTAL;
        end else if (tick && ((r_state == ST_WALK) || (r_state == ST_CLEAR))) begin
            r_countdown <= r_countdown - c_ONE;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ped_crossing_ctrl.sv
// ============================================================================
// Module : tb_ped_crossing_ctrl
// Brief  : Directed scoreboard bench for ped_crossing_ctrl (default parameters).
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ped_crossing_ctrl;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic btn_raw;
    logic veh_red;
    logic veh_green;
    logic veh_yellow;
    logic walk;
    logic dont_walk;
    logic req_pending;
    logic fault;
`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] countdown;
`endif

    typedef struct {
        string      tag;
        logic [3:0] lamps;   // {walk, dont_walk, req_pending, fault}
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ped_crossing_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_raw     (btn_raw),
        .veh_red     (veh_red),
        .veh_green   (veh_green),
        .veh_yellow  (veh_yellow),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .fault       (fault)
`ifdef PED_COUNTDOWN_EN
        ,
        .countdown   (countdown)
`endif
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic w, input logic dw, input logic rp, input logic f);
        exp_t e;
        e.tag   = tag;
        e.lamps = {w, dw, rp, f};
        q_exp.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [3:0] obs;
        n_tests++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed nothing queued, required one expectation");
        end else begin
            e   = q_exp.pop_front();
            obs = {walk, dont_walk, req_pending, fault};
            assert (obs === e.lamps) else begin
                n_fail++;
                $error("FAIL %s: observed walk/dw/req/fault=%b expected %b", e.tag, obs, e.lamps);
            end
        end
    endtask

`ifdef PED_COUNTDOWN_EN
    task automatic check_cd(input string tag, input logic [CNT_W-1:0] exp_cd);
        n_tests++;
        assert (countdown === exp_cd) else begin
            n_fail++;
            $error("FAIL %s: observed countdown=%0d expected %0d", tag, countdown, exp_cd);
        end
    endtask
`endif

    task automatic latch_request();
        btn_raw = 1'b1;
        cyc(8);
        btn_raw = 1'b0;
        cyc(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        tick       = 1'b1;
        btn_raw    = 1'b0;
        veh_red    = 1'b0;
        veh_green  = 1'b1;
        veh_yellow = 1'b0;
        cyc(2);
        push("reset", 0, 1, 0, 0); pop_check();
        rst = 1'b0;
        cyc(2);

        // 1: press during green, full crossing cycle
        btn_raw = 1'b1;
        push("t1_debouncing", 0, 1, 0, 0); cyc(6); pop_check();
        push("t1_req_latched", 0, 1, 1, 0); cyc(1); pop_check();
        btn_raw = 1'b0;
        cyc(10);
        veh_green = 1'b0; veh_red = 1'b1;
        push("t1_walk_on", 1, 0, 0, 0); cyc(1); pop_check();
`ifdef PED_COUNTDOWN_EN
        check_cd("t1_cd_start", 4'd9);
`endif
        push("t1_walk_last", 1, 0, 0, 0); cyc(5); pop_check();
        push("t1_clear_a", 0, 1, 0, 0); cyc(1); pop_check();
        push("t1_clear_b", 0, 0, 0, 0); cyc(1); pop_check();
        push("t1_clear_c", 0, 1, 0, 0); cyc(1); pop_check();
        push("t1_done_a", 0, 1, 0, 0); cyc(1); pop_check();
        push("t1_done_b", 0, 1, 0, 0); cyc(1); pop_check();
`ifdef PED_COUNTDOWN_EN
        check_cd("t1_cd_end", 4'd0);
`endif

        // 2: short glitch ignored, dark lamps legal, red passes without WALK
        veh_red = 1'b0; veh_green = 1'b1;
        cyc(2);
        btn_raw = 1'b1; cyc(2); btn_raw = 1'b0;
        push("t2_no_req", 0, 1, 0, 0); cyc(10); pop_check();
        veh_green = 1'b0;
        push("t2_dark_ok", 0, 1, 0, 0); cyc(3); pop_check();
        veh_red = 1'b1;
        push("t2_no_walk", 0, 1, 0, 0); cyc(1); pop_check();
        push("t2_red_phase", 0, 1, 0, 0); cyc(8); pop_check();

        // 3: press coincident with red rise, press in CLEAR, press in WALK
        veh_red = 1'b0; veh_green = 1'b1;
        cyc(2);
        btn_raw = 1'b1; cyc(6);
        veh_red = 1'b1; veh_green = 1'b0;
        push("t3_simul_walk", 1, 0, 0, 0); cyc(1); pop_check();
        btn_raw = 1'b0;
        push("t3_simul_done", 0, 1, 0, 0); cyc(12); pop_check();
        veh_red = 1'b0; veh_green = 1'b1;
        latch_request();
        push("t3_req2", 0, 1, 1, 0); pop_check();
        veh_red = 1'b1; veh_green = 1'b0;
        push("t3_walk2", 1, 0, 0, 0); cyc(1); pop_check();
        cyc(1);
        btn_raw = 1'b1;
        push("t3_clear_press_latched", 0, 1, 1, 0); cyc(8); pop_check();
        btn_raw = 1'b0;
        veh_red = 1'b0; veh_green = 1'b1;
        cyc(10);
        btn_raw = 1'b1;
        cyc(3);
        veh_red = 1'b1; veh_green = 1'b0;
        push("t3_pending_served", 1, 0, 0, 0); cyc(1); pop_check();
        push("t3_walk_press_ignored", 0, 1, 0, 0); cyc(10); pop_check();
        btn_raw = 1'b0;

        // 4: red lost during WALK -> sticky fault, cleared only by async reset
        veh_red = 1'b0; veh_green = 1'b1;
        cyc(10);
        latch_request();
        veh_red = 1'b1; veh_green = 1'b0;
        cyc(1);
        cyc(3);
        veh_red = 1'b0;
        push("t4_fault", 0, 1, 0, 1); cyc(1); pop_check();
        veh_green = 1'b1;
        push("t4_fault_sticky", 0, 1, 0, 1); cyc(5); pop_check();
        rst = 1'b1;
        #1;
        push("t4_async_reset", 0, 1, 0, 0); pop_check();
        cyc(1);
        rst = 1'b0;
        cyc(2);

        // 5: conflicting lamps fault; tick held low freezes WALK
        veh_red = 1'b1;
        push("t5_multi_fault", 0, 1, 0, 1); cyc(1); pop_check();
        rst = 1'b1; veh_red = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        latch_request();
        veh_red = 1'b1; veh_green = 1'b0;
        cyc(1);
        cyc(2);
        tick = 1'b0;
        push("t5_frozen", 1, 0, 0, 0); cyc(20); pop_check();
        tick = 1'b1;
        push("t5_resume", 1, 0, 0, 0); cyc(3); pop_check();
        push("t5_to_clear", 0, 1, 0, 0); cyc(1); pop_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
